// File: rtl/life_array_param_if.sv
// Host-side bundle for the Life array: row load/readback, stepping, the run
// sequencer controls and the status outputs.
interface life_array_param_if #(
    parameter int COLS   = 16,
    parameter int RSEL_W = 4,
    parameter int GEN_W  = 16
);
    logic [COLS-1:0]   vali;
    logic [RSEL_W-1:0] vali_selector;
    logic              write_enb;
    logic [RSEL_W-1:0] valo_selector;
    logic [COLS-1:0]   valo;
    logic [COLS-1:0]   valo_prev;
    logic              step;
    logic              run_start;
    logic [GEN_W-1:0]  run_count;
    logic              busy;
    logic [GEN_W-1:0]  generation;
    logic              stable;
    logic              extinct;

    modport master (
        output vali, vali_selector, write_enb, valo_selector, step, run_start, run_count,
        input  valo, valo_prev, busy, generation, stable, extinct
    );
    modport slave (
        input  vali, vali_selector, write_enb, valo_selector, step, run_start, run_count,
        output valo, valo_prev, busy, generation, stable, extinct
    );
endinterface

// File: rtl/life_array_param.sv
// ROWS x COLS Conway B3/S23 array with optional torus wrap, run-N sequencer,
// generation counter and still-life / extinction flags.
module life_cell (
    input  logic       cur_i,
    input  logic [7:0] nbr_i,
    output logic       nxt_o
);
    logic [3:0] cnt;

    always_comb begin
        cnt = '0;
        for (int k = 0; k < 8; k++) cnt = cnt + {3'b000, nbr_i[k]};
    end

    assign nxt_o = (cnt == 4'd3) | (cur_i & (cnt == 4'd2));
endmodule

module life_array_param #(
    parameter int ROWS   = 16,
    parameter int COLS   = 16,
    parameter int WRAP   = 0,
    parameter int GEN_W  = 16,
    parameter int RSEL_W = 4
) (
    input  logic            clk,
    input  logic            reset,
    life_array_param_if.slave host,
    input  logic [COLS-1:0] ni,
    input  logic [COLS-1:0] si,
    input  logic [ROWS-1:0] wi,
    input  logic [ROWS-1:0] ei,
    input  logic            nwi,
    input  logic            nei,
    input  logic            sei,
    input  logic            swi,
    output logic [COLS-1:0] no,
    output logic [COLS-1:0] so,
    output logic [ROWS-1:0] wo,
    output logic [ROWS-1:0] eo,
    output logic            nwo,
    output logic            neo,
    output logic            seo,
    output logic            swo
);
    localparam logic [RSEL_W:0] ROWS_L = (RSEL_W+1)'(ROWS);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    logic [ROWS-1:0][COLS-1:0]     grid_q, prev_q, nxt;
    logic [ROWS+1:0][COLS+1:0]     ext;
    logic [GEN_W-1:0]              gen_q, rem_q, rem_d;
    logic                          stable_q;
    state_t                        state_q, state_d;
    logic                          adv, start_ok, wr_ok, rd_ok;

    assign start_ok = host.run_start && (host.run_count != '0);
    assign wr_ok    = {1'b0, host.vali_selector} < ROWS_L;
    assign rd_ok    = {1'b0, host.valo_selector} < ROWS_L;

    // Grid surrounded by a one-cell halo; the halo is either the edge ports
    // or the opposite side of the grid.
    always_comb begin
        ext = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) ext[r+1][c+1] = grid_q[r][c];
        if (WRAP != 0) begin
            for (int c = 0; c < COLS; c++) begin
                ext[0][c+1]      = grid_q[ROWS-1][c];
                ext[ROWS+1][c+1] = grid_q[0][c];
            end
            for (int r = 0; r < ROWS; r++) begin
                ext[r+1][0]      = grid_q[r][COLS-1];
                ext[r+1][COLS+1] = grid_q[r][0];
            end
            ext[0][0]           = grid_q[ROWS-1][COLS-1];
            ext[0][COLS+1]      = grid_q[ROWS-1][0];
            ext[ROWS+1][COLS+1] = grid_q[0][0];
            ext[ROWS+1][0]      = grid_q[0][COLS-1];
        end else begin
            for (int c = 0; c < COLS; c++) begin
                ext[0][c+1]      = ni[c];
                ext[ROWS+1][c+1] = si[c];
            end
            for (int r = 0; r < ROWS; r++) begin
                ext[r+1][0]      = wi[r];
                ext[r+1][COLS+1] = ei[r];
            end
            ext[0][0]           = nwi;
            ext[0][COLS+1]      = nei;
            ext[ROWS+1][COLS+1] = sei;
            ext[ROWS+1][0]      = swi;
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            life_cell u_cell (
                .cur_i (grid_q[r][c]),
                .nbr_i ({ext[r][c],   ext[r][c+1],   ext[r][c+2],
                         ext[r+1][c],                ext[r+1][c+2],
                         ext[r+2][c], ext[r+2][c+1], ext[r+2][c+2]}),
                .nxt_o (nxt[r][c])
            );
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    // A write stalls a run for one cycle without consuming a generation.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        case (state_q)
            S_IDLE: if (start_ok) begin
                state_d = S_RUN;
                rem_d   = host.run_count;
            end
            S_RUN: if (!host.write_enb) begin
                rem_d = rem_q - 1'b1;
                if (rem_q == GEN_W'(1)) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        adv = 1'b0;
        case (state_q)
            S_IDLE:  adv = host.step && !host.write_enb && !host.run_start;
            S_RUN:   adv = !host.write_enb;
            default: adv = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grid_q   <= '0;
            prev_q   <= '0;
            gen_q    <= '0;
            stable_q <= 1'b0;
        end else if (host.write_enb) begin
            if (wr_ok) grid_q[host.vali_selector] <= host.vali;
            stable_q <= 1'b0;
        end else if (adv) begin
            prev_q   <= grid_q;
            grid_q   <= nxt;
            gen_q    <= gen_q + 1'b1;
            stable_q <= (nxt == grid_q);
        end
    end

    assign host.valo       = rd_ok ? grid_q[host.valo_selector] : '0;
    assign host.valo_prev  = rd_ok ? prev_q[host.valo_selector] : '0;
    assign host.busy       = (state_q == S_RUN);
    assign host.generation = gen_q;
    assign host.stable     = stable_q;
    assign host.extinct    = ~|grid_q;

    assign no  = grid_q[0];
    assign so  = grid_q[ROWS-1];
    always_comb begin
        wo = '0;
        eo = '0;
        for (int r = 0; r < ROWS; r++) begin
            wo[r] = grid_q[r][0];
            eo[r] = grid_q[r][COLS-1];
        end
    end
    assign nwo = grid_q[0][0];
    assign neo = grid_q[0][COLS-1];
    assign seo = grid_q[ROWS-1][COLS-1];
    assign swo = grid_q[ROWS-1][0];
endmodule

// File: doc/life_array_param.md
Name: life_array_param

Overview:
- Parametrised successor to the fixed 16x16 Life array: a ROWS x COLS grid of Conway B3/S23 cells.
- Adds over the fixed array:
  - optional toroidal wrap;
  - an autonomous run-N-generations sequencer with busy flag;
  - a generation counter;
  - still-life and extinction detection.
- Tiles with neighbouring arrays through edge/corner ports when not wrapping.
- Host loads and reads rows through the selector interface.

Parameters:
- ROWS, 16, number of rows (>=3); row 0 = north edge.
- COLS, 16, number of columns (>=3); bit 0 of a row word = west column.
- WRAP, 0, 0 = edge neighbours from edge ports; 1 = toroidal (edge inputs ignored).
- GEN_W, 16, width of generation counter and run_count.
- RSEL_W, 4, row selector width; must satisfy 2^RSEL_W >= ROWS.

Ports:
- clk  input  1  clock.
- reset  input  1  one clock; reset is asynchronous and active-low.
- vali  input  COLS  row data to write.
- vali_selector  input  RSEL_W  row index for write.
- write_enb  input  1  write vali into row vali_selector this cycle.
- valo_selector  input  RSEL_W  row index for readback.
- valo  output  COLS  current state of row valo_selector (combinational read).
- valo_prev  output  COLS  previous-generation state of row valo_selector.
- step  input  1  advance one generation per cycle while high.
- run_start  input  1  pulse: begin autonomous run of run_count generations.
- run_count  input  GEN_W  generations to run; sampled on run_start.
- busy  output  1  autonomous run in progress.
- ni, si  input  COLS  neighbour rows beyond north/south edges.
- wi, ei  input  ROWS  neighbour columns beyond west/east edges.
- nwi, nei, sei, swi  input  1  diagonal corner neighbours.
- no, so  output  COLS  row 0 / row ROWS-1 state.
- wo, eo  output  ROWS  column 0 / column COLS-1 state; bit r = row r.
- nwo, neo, seo, swo  output  1  corner cells (0,0), (0,COLS-1), (ROWS-1,COLS-1), (ROWS-1,0).
- generation  output  GEN_W  generations computed since reset.
- stable  output  1  last computed generation equalled its predecessor.
- extinct  output  1  all cells dead (combinational).

Behaviour:
- Reset (async, reset=0):
  - all cells and prev copies = 0; generation=0; busy=0; stable=0.
  - Consequently valo=valo_prev=0, all edge/corner outputs 0, extinct=1.
- Advance event: one generation computed on a rising edge.
  - All cells update simultaneously from the current grid.
  - prev copy <= current grid; generation <= generation+1 (wraps modulo 2^GEN_W).
  - stable <= (next grid == current grid).
- Cell rule:
  - Neighbour count 0..8 from 8 neighbours.
  - Dead cell becomes alive on count==3; live cell survives on count 2 or 3; otherwise dead.
- Neighbours off-grid:
  - WRAP=0: taken from ni/si/wi/ei/corners, bit-aligned with the grid row/column index.
  - WRAP=1: modulo ROWS/COLS.
- Priority per cycle: write_enb > busy run > step.
  - write_enb=1: row vali_selector <= vali; no advance that cycle; stable <= 0; prev copy and generation unchanged.
  - Selector >= ROWS: write ignored; valo/valo_prev read 0.
- Sequencer FSM:
  - IDLE: step=1 -> advance each cycle. run_start=1 with run_count>0 -> load remaining=run_count, go RUN, busy=1 next cycle. run_start with run_count=0 -> stay IDLE, no advance.
  - RUN: advance each cycle not overridden by write_enb (write stalls the run one cycle; remaining unchanged). remaining decrements per advance; advance with remaining==1 -> IDLE, busy=0 the following cycle. step and run_start ignored in RUN.
  - Exactly run_count advances occur; no early abort except reset.
- Reset mid-run: immediate return to IDLE and the full reset state.
- Edge/corner outputs reflect registered cell state only; no combinational path from inputs to outputs except valo/valo_prev via the selectors.

Test Plan:
- Write row 0 = 0x0001, read valo_selector=0 -> valo=0x0001, nwo=1, extinct=0, generation=0.
- Blinker (WRAP=0, 16x16, edges 0), row 5 = 0x0070, one step -> rows 4,5,6 = 0x0020, valo_prev(row5)=0x0070, generation=1, stable=0. Second step -> row 5 = 0x0070 again.
- 2x2 block at rows 1-2 = 0x0006, run_start with run_count=5 -> busy high exactly 5 cycles, generation=5, stable=1, grid unchanged.
- WRAP=1 glider at top-left, run_count=64 -> grid identical to initial load, generation=64, busy low after.
- Row 0 = 0x0007, ni=0x0002 (WRAP=0), one step -> row 0 = 0x0007 (birth/survival uses north input).
- Mid-run (run_count=10, after 3 advances) write_enb for one cycle -> run stretches to 11 cycles, generation=10. Reset low mid-run -> busy=0, generation=0, extinct=1 immediately.
